draw_vramwr: RTL and testbench

// Downstream drain stage of the drawing write FIFO. Pops 64-bit pixel words from the FIFO,

---
 rtl/draw_vramwr.sv | 148 ++++++++++++++
 tb/tb_draw_vramwr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_vramwr.sv
// Drain stage of the drawing write FIFO: pops pixel words and emits them as
// VRAM write bursts of up to BURST_LEN beats through a 2-entry skid queue.
module draw_vramwr #(
  parameter int ADDR_W    = 22,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 8
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              DRW_START,
  input  logic [ADDR_W-1:0] DRW_BASEADDR,
  input  logic [CNT_W-1:0]  DRW_WORDS,
  output logic              DRW_BUSY,
  output logic              DRW_DONE,
  output logic              DRW_ERR,
  output logic              BUF_RD,
  input  logic [63:0]       DRW_VRAMWDATA,
  input  logic              DATAVALID,
  input  logic              EMPTY_VRAM,
  input  logic              BUF_UNDER,
  output logic              VRAM_REQ,
  input  logic              VRAM_GNT,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [4:0]        VRAM_BLEN,
  output logic              VRAM_WEN,
  output logic [63:0]       VRAM_WDATA,
  input  logic              VRAM_WREADY
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   remaining;
  logic [4:0]         blen;
  logic [4:0]         fetched;
  logic [4:0]         written;
  logic               rd_inflight;
  logic [1:0]         qcnt;
  logic [63:0]        q0, q1;
  logic               err;

  logic               in_write, rd, wen, pop, push, last_beat;
  logic [CNT_W-1:0]   rem_next;

  function automatic logic [4:0] burst_of(input logic [CNT_W-1:0] r);
    if (r >= CNT_W'(BURST_LEN)) return 5'(BURST_LEN);
    return r[4:0];
  endfunction

  always_comb begin
    in_write  = (state == S_WRITE);
    // Outstanding FIFO reads count against queue space so a late DATAVALID always fits.
    rd        = in_write && !EMPTY_VRAM &&
                ((3'(qcnt) + 3'(rd_inflight)) < 3'd2) && (fetched < blen);
    wen       = in_write && (qcnt != 2'd0);
    pop       = wen && VRAM_WREADY;
    push      = in_write && DATAVALID && ((qcnt != 2'd2) || pop);
    last_beat = pop && (written == blen - 5'd1);
    rem_next  = remaining - CNT_W'(blen);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      blen        <= '0;
      fetched     <= '0;
      written     <= '0;
      rd_inflight <= 1'b0;
      qcnt        <= '0;
      q0          <= '0;
      q1          <= '0;
      err         <= 1'b0;
    end else begin
      rd_inflight <= rd;

      if (state == S_IDLE && DRW_START) err <= 1'b0;
      if (BUF_UNDER)                    err <= 1'b1;

      case ({push, pop})
        2'b10: begin
          if (qcnt == 2'd0) q0 <= DRW_VRAMWDATA;
          else              q1 <= DRW_VRAMWDATA;
          qcnt <= qcnt + 2'd1;
        end
        2'b01: begin
          q0   <= q1;
          qcnt <= qcnt - 2'd1;
        end
        2'b11: begin
          if (qcnt == 2'd1) q0 <= DRW_VRAMWDATA;
          else begin
            q0 <= q1;
            q1 <= DRW_VRAMWDATA;
          end
        end
        default: ;
      endcase

      if (rd)  fetched <= fetched + 5'd1;
      if (pop) written <= written + 5'd1;

      case (state)
        S_IDLE: if (DRW_START) begin
          addr      <= DRW_BASEADDR;
          remaining <= DRW_WORDS;
          if (DRW_WORDS != '0) begin
            blen  <= burst_of(DRW_WORDS);
            state <= S_REQ;
          end else begin
            state <= S_DONE;
          end
        end
        S_REQ: if (VRAM_GNT) begin
          fetched <= '0;
          written <= '0;
          state   <= S_WRITE;
        end
        S_WRITE: if (last_beat) begin
          // Address wraps silently; a burst crossing the top is not split.
          addr      <= addr + ADDR_W'(blen);
          remaining <= rem_next;
          if (rem_next != '0) begin
            blen  <= burst_of(rem_next);
            state <= S_REQ;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign DRW_BUSY   = (state != S_IDLE);
  assign DRW_DONE   = (state == S_DONE);
  assign DRW_ERR    = err;
  assign BUF_RD     = rd;
  assign VRAM_REQ   = (state == S_REQ);
  assign VRAM_ADDR  = addr;
  assign VRAM_BLEN  = blen;
  assign VRAM_WEN   = wen;
  assign VRAM_WDATA = wen ? q0 : 64'd0;

endmodule

// File: tb/tb_draw_vramwr.sv
// Bench for draw_vramwr: FIFO/arbiter/VRAM-port models plus an expected beat
// stream derived from base/word-count arithmetic.
module tb_draw_vramwr;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DRW_START;
  logic [21:0] DRW_BASEADDR;
  logic [15:0] DRW_WORDS;
  logic        DRW_BUSY, DRW_DONE, DRW_ERR, BUF_RD;
  logic [63:0] DRW_VRAMWDATA;
  logic        DATAVALID, EMPTY_VRAM, BUF_UNDER;
  logic        VRAM_REQ, VRAM_GNT;
  logic [21:0] VRAM_ADDR;
  logic [4:0]  VRAM_BLEN;
  logic        VRAM_WEN;
  logic [63:0] VRAM_WDATA;
  logic        VRAM_WREADY;

  draw_vramwr dut (
    .CLK(CLK), .RST(RST), .DRW_START(DRW_START), .DRW_BASEADDR(DRW_BASEADDR),
    .DRW_WORDS(DRW_WORDS), .DRW_BUSY(DRW_BUSY), .DRW_DONE(DRW_DONE), .DRW_ERR(DRW_ERR),
    .BUF_RD(BUF_RD), .DRW_VRAMWDATA(DRW_VRAMWDATA), .DATAVALID(DATAVALID),
    .EMPTY_VRAM(EMPTY_VRAM), .BUF_UNDER(BUF_UNDER), .VRAM_REQ(VRAM_REQ),
    .VRAM_GNT(VRAM_GNT), .VRAM_ADDR(VRAM_ADDR), .VRAM_BLEN(VRAM_BLEN),
    .VRAM_WEN(VRAM_WEN), .VRAM_WDATA(VRAM_WDATA), .VRAM_WREADY(VRAM_WREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [21:0] a;
    logic [4:0]  bl;
    logic [63:0] d;
  } beat_t;

  int tests = 0, fails = 0;
  int cyc = 0;
  int jid = 0;
  int wr_mode = 0;
  logic [63:0] fifo[$];
  beat_t       expq[$];
  logic [21:0] req_a[$];
  logic [4:0]  req_b[$];
  int rd_cnt = 0, done_cnt = 0, beats = 0, bubbles = 0;
  int occ = 0, gnt_cyc = 0, lat_rd = -1, lat_wen = -1;
  logic rd_prev = 1'b0, req_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int j, input int i);
    return {8'hD0, 8'(j), 16'(i), 32'hC0DE0000 ^ 32'(j * 97 + i)};
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO: a pop decided this cycle returns its word with DATAVALID next cycle.
  initial begin
    logic r;
    DATAVALID = 1'b0; DRW_VRAMWDATA = '0; EMPTY_VRAM = 1'b1;
    forever begin
      @(negedge CLK); r = BUF_RD;
      @(posedge CLK); #1;
      if (r && fifo.size() > 0) begin
        DRW_VRAMWDATA = fifo.pop_front();
        DATAVALID = 1'b1;
      end else DATAVALID = 1'b0;
      EMPTY_VRAM = (fifo.size() == 0);
    end
  end

  // Arbiter: grant for one cycle, one cycle after REQ is seen.
  initial begin
    VRAM_GNT = 1'b0;
    forever begin
      @(negedge CLK);
      if (VRAM_REQ && !VRAM_GNT) begin
        @(posedge CLK); #1 VRAM_GNT = 1'b1;
        @(posedge CLK); #1 VRAM_GNT = 1'b0;
      end
    end
  end

  initial begin
    VRAM_WREADY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      VRAM_WREADY = (wr_mode != 0) ? ~VRAM_WREADY : 1'b1;
    end
  end

  // Compare process: every accepted beat against the expected stream, plus queue invariants.
  always @(negedge CLK) begin
    logic  inwrite;
    beat_t e;
    if (RST) begin
      occ = 0; rd_prev = 1'b0; req_prev = 1'b0;
    end else begin
      inwrite = DRW_BUSY && !VRAM_REQ && !DRW_DONE;
      if (VRAM_REQ && !req_prev) begin
        req_a.push_back(VRAM_ADDR); req_b.push_back(VRAM_BLEN);
        if (expq.size() > 0) begin
          chk("req_addr", 64'(VRAM_ADDR), 64'(expq[0].a));
          chk("req_blen", 64'(VRAM_BLEN), 64'(expq[0].bl));
        end
      end
      if (VRAM_REQ && VRAM_GNT) begin gnt_cyc = cyc; lat_rd = -1; lat_wen = -1; end
      if (BUF_RD && lat_rd < 0)   lat_rd  = cyc - gnt_cyc;
      if (VRAM_WEN && lat_wen < 0) lat_wen = cyc - gnt_cyc;
      if (inwrite) begin
        chk("queue_le2", 64'(occ <= 2), 64'd1);
        if (occ + int'(rd_prev) == 2) chk("rd_hold", 64'(BUF_RD), 64'd0);
        if (!VRAM_WEN) bubbles++;
      end
      if (VRAM_WEN && VRAM_WREADY) begin
        if (expq.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          chk("beat_data", VRAM_WDATA, e.d);
          chk("beat_addr", 64'(VRAM_ADDR), 64'(e.a));
          chk("beat_blen", 64'(VRAM_BLEN), 64'(e.bl));
        end
        beats++;
      end
      if (BUF_RD) rd_cnt++;
      if (DRW_DONE) done_cnt++;
      if (inwrite && DATAVALID) occ++;
      if (VRAM_WEN && VRAM_WREADY) occ--;
      rd_prev = BUF_RD; req_prev = VRAM_REQ;
    end
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(dat(jid, i));
  endtask

  // Expected stream: word i goes to burst i/8 at base+8*(i/8), length min(rest, 8).
  task automatic do_start(input logic [21:0] base, input int words);
    beat_t b;
    @(posedge CLK); #1;
    DRW_START = 1'b1; DRW_BASEADDR = base; DRW_WORDS = 16'(words);
    for (int i = 0; i < words; i++) begin
      b.a  = base + 22'((i / 8) * 8);
      b.bl = 5'(((words - (i / 8) * 8) > 8) ? 8 : (words - (i / 8) * 8));
      b.d  = dat(jid, i);
      expq.push_back(b);
    end
    jid++;
    @(posedge CLK); #1;
    DRW_START = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int n = 0;
    while (!DRW_DONE && n < max) begin @(negedge CLK); n++; end
    chk(nm, 64'(DRW_DONE), 64'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, 64'(DRW_BUSY), 64'd0);
    chk({nm, "_done"}, 64'(DRW_DONE), 64'd0);
    chk({nm, "_rd"},   64'(BUF_RD),   64'd0);
    chk({nm, "_req"},  64'(VRAM_REQ), 64'd0);
    chk({nm, "_wen"},  64'(VRAM_WEN), 64'd0);
    chk({nm, "_addr_blen_wdata"}, 64'(VRAM_ADDR) | 64'(VRAM_BLEN) | VRAM_WDATA, 64'd0);
  endtask

  initial begin
    int rd0, rq0, d0, bb0, b0, n;
    RST = 1'b1; DRW_START = 1'b0; DRW_BASEADDR = '0; DRW_WORDS = '0; BUF_UNDER = 1'b0;
    repeat (3) @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk_idle_outputs("reset");
    chk("reset_err", 64'(DRW_ERR), 64'd0);

    // Zero-word job: DONE straight after START, no requests or pops.
    rd0 = rd_cnt; rq0 = req_a.size(); d0 = done_cnt;
    do_start(22'h55, 0);
    @(negedge CLK);
    chk("w0_done", 64'(DRW_DONE), 64'd1);
    chk("w0_busy", 64'(DRW_BUSY), 64'd1);
    @(negedge CLK);
    chk("w0_done_clr", 64'(DRW_DONE), 64'd0);
    chk("w0_busy_clr", 64'(DRW_BUSY), 64'd0);
    repeat (4) @(negedge CLK);
    chk("w0_no_rd",  64'(rd_cnt - rd0), 64'd0);
    chk("w0_no_req", 64'(req_a.size() - rq0), 64'd0);
    chk("w0_one_done", 64'(done_cnt - d0), 64'd1);

    // 20 words from 0x100, prefilled FIFO.
    rd0 = rd_cnt; rq0 = req_a.size(); d0 = done_cnt;
    fill(20);
    do_start(22'h100, 20);
    chk("model_pin_a",  64'(expq[19].a),  64'h110);
    chk("model_pin_bl", 64'(expq[19].bl), 64'd4);
    chk("model_pin_b0", 64'(expq[8].a),   64'h108);
    wait_done("t20_done", 300);
    chk("t20_nreq", 64'(req_a.size() - rq0), 64'd3);
    if (req_a.size() - rq0 == 3) begin
      chk("t20_a0", 64'(req_a[rq0]),   64'h100); chk("t20_b0", 64'(req_b[rq0]),   64'd8);
      chk("t20_a1", 64'(req_a[rq0+1]), 64'h108); chk("t20_b1", 64'(req_b[rq0+1]), 64'd8);
      chk("t20_a2", 64'(req_a[rq0+2]), 64'h110); chk("t20_b2", 64'(req_b[rq0+2]), 64'd4);
    end
    chk("t20_rd",    64'(rd_cnt - rd0), 64'd20);
    chk("t20_ndone", 64'(done_cnt - d0), 64'd1);
    chk("t20_lat_rd",  64'(lat_rd),  64'd1);
    chk("t20_lat_wen", 64'(lat_wen), 64'd3);
    chk("t20_drained", 64'(expq.size()), 64'd0);

    // WREADY toggling.
    rd0 = rd_cnt;
    wr_mode = 1;
    fill(16);
    do_start(22'h40, 16);
    wait_done("tgl_done", 400);
    wr_mode = 0;
    chk("tgl_rd", 64'(rd_cnt - rd0), 64'd16);
    chk("tgl_drained", 64'(expq.size()), 64'd0);
    chk("tgl_fifo_empty", 64'(fifo.size()), 64'd0);

    // FIFO trickle: one word every 5 cycles.
    rq0 = req_a.size(); bb0 = bubbles; n = jid;
    do_start(22'h200, 16);
    for (int i = 0; i < 16; i++) begin
      repeat (5) @(posedge CLK); #1;
      fifo.push_back(dat(n, i));
    end
    wait_done("trk_done", 100);
    chk("trk_nreq", 64'(req_a.size() - rq0), 64'd2);
    if (req_a.size() - rq0 == 2) begin
      chk("trk_a0", 64'(req_a[rq0]),   64'h200); chk("trk_b0", 64'(req_b[rq0]),   64'd8);
      chk("trk_a1", 64'(req_a[rq0+1]), 64'h208); chk("trk_b1", 64'(req_b[rq0+1]), 64'd8);
    end
    chk("trk_bubbles", 64'(bubbles > bb0), 64'd1);
    chk("trk_drained", 64'(expq.size()), 64'd0);

    // Address wrap.
    rq0 = req_a.size();
    fill(12);
    do_start(22'h3FFFFC, 12);
    wait_done("wrap_done", 200);
    chk("wrap_nreq", 64'(req_a.size() - rq0), 64'd2);
    if (req_a.size() - rq0 == 2) begin
      chk("wrap_a0", 64'(req_a[rq0]),   64'h3FFFFC); chk("wrap_b0", 64'(req_b[rq0]),   64'd8);
      chk("wrap_a1", 64'(req_a[rq0+1]), 64'h000004); chk("wrap_b1", 64'(req_b[rq0+1]), 64'd4);
    end
    chk("wrap_drained", 64'(expq.size()), 64'd0);

    // Reset in the middle of a burst.
    b0 = beats; d0 = done_cnt;
    fill(16);
    do_start(22'h0, 16);
    n = 0;
    while ((beats - b0) < 3 && n < 100) begin @(negedge CLK); n++; end
    chk("rst_reached_beat3", 64'((beats - b0) >= 3), 64'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    fifo.delete(); expq.delete();
    @(negedge CLK);
    chk_idle_outputs("midrst");
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    repeat (3) @(posedge CLK);
    #1 fifo.delete();

    // Job after reset, with an underflow pulse mid-job.
    fill(8);
    do_start(22'h0, 8);
    repeat (3) @(posedge CLK); #1 BUF_UNDER = 1'b1;
    @(posedge CLK); #1 BUF_UNDER = 1'b0;
    @(negedge CLK);
    chk("err_set", 64'(DRW_ERR), 64'd1);
    wait_done("post_rst_done", 200);
    chk("post_rst_drained", 64'(expq.size()), 64'd0);
    chk("err_sticky", 64'(DRW_ERR), 64'd1);
    do_start(22'h0, 0);
    @(negedge CLK);
    chk("err_clr_on_start", 64'(DRW_ERR), 64'd0);
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
